dili_sample_capture: RTL

- Sits between the Dilithium sampler core (producer of i_samples) and the CW305 host-interface register block (consumer).
- In the crypto_clk domain, captures a fixed-length burst of packed sampler words into a FIFO after a start pulse.
- Presents FIFO status and a pop/read port so the register block can read results after the crypto operation.
- Applies backpressure to the sampler and records dropped words.

---
 rtl/dili_sample_capture.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/dili_sample_capture.sv
// -----------------------------------------------------------------------------
// dili_sample_capture
//
// Captures a fixed-length burst of packed Dilithium sampler words into a FIFO
// after a start pulse, all in the crypto_clk domain, and offers a pop/read
// port plus status so the CW305 register block can drain results.
//
// Ports:
//   crypto_clk  - sole clock, rising edge
//   reset_i     - synchronous active-high reset
//   i_start     - one-cycle pulse: flush FIFO, clear status, arm capture
//   i_valid     - sampler word valid
//   i_samples   - packed sampler word, coefficient 0 in the LSBs
//   o_ready     - capture accepts a word this cycle
//   i_rd        - pop request
//   o_rd_data   - popped word (held between pops)
//   o_rd_valid  - one-cycle pulse, o_rd_data valid
//   o_count     - words currently held
//   o_empty     - o_count == 0
//   o_full      - o_count == pDEPTH
//   o_captured  - words accepted since the last start
//   o_overflow  - sticky: a word was dropped during capture
//   o_busy      - capture in progress
//   o_done      - capture complete, FIFO not yet drained
// -----------------------------------------------------------------------------
module dili_sample_capture #(
  parameter int pOUTPUT_W    = 4,
  parameter int pCOEFF_W     = 23,
  parameter int pDEPTH       = 64,
  parameter int pCAPTURE_LEN = 256,
  parameter int pCNT_W       = 16
) (
  input  logic                             crypto_clk,
  input  logic                             reset_i,
  input  logic                             i_start,
  input  logic                             i_valid,
  input  logic [pOUTPUT_W*pCOEFF_W-1:0]    i_samples,
  output logic                             o_ready,
  input  logic                             i_rd,
  output logic [pOUTPUT_W*pCOEFF_W-1:0]    o_rd_data,
  output logic                             o_rd_valid,
  output logic [$clog2(pDEPTH):0]          o_count,
  output logic                             o_empty,
  output logic                             o_full,
  output logic [pCNT_W-1:0]                o_captured,
  output logic                             o_overflow,
  output logic                             o_busy,
  output logic                             o_done
);

  localparam int DATA_W = pOUTPUT_W * pCOEFF_W;
  localparam int PTR_W  = $clog2(pDEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(pDEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ZERO   = PTR_W'(0);
  localparam logic [pCNT_W-1:0] CAP_ONE    = pCNT_W'(1);
  localparam logic [pCNT_W-1:0] CAP_ZERO   = pCNT_W'(0);
  localparam logic [pCNT_W-1:0] CAP_LAST   = pCNT_W'(pCAPTURE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [pCNT_W-1:0]   captured_q, captured_d;
  logic                overflow_q, overflow_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]   mem_q [pDEPTH];

  logic                ready_s;
  logic                push_s;
  logic                pop_s;
  logic                drop_s;

  // Handshake decode and next-state computation for pointers, status and FSM.
  always_comb begin
    // Ready looks only at registered occupancy: a same-cycle pop never frees
    // room for a push.
    ready_s = (state_q == ST_CAPTURE) && (count_q != DEPTH_C);
    // A start pulse discards any push or pop in its own cycle.
    push_s  = i_valid && ready_s && !i_start;
    pop_s   = i_rd && (count_q != CNT_ZERO) && !i_start;
    drop_s  = i_valid && (state_q == ST_CAPTURE) && !ready_s && !i_start;

    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    captured_d = captured_q;
    overflow_d = overflow_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    if (i_start) begin
      state_d    = ST_CAPTURE;
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      count_d    = CNT_ZERO;
      captured_d = CAP_ZERO;
      overflow_d = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d   = wr_ptr_q + PTR_ONE;
        captured_d = captured_q + CAP_ONE;
      end else begin
        wr_ptr_d   = wr_ptr_q;
      end

      if (pop_s) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
      end

      if (drop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase

      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_CAPTURE: begin
          // The last word of the burst moves us to DONE; captured cannot
          // advance beyond the burst length because pushes stop there.
          if (push_s && (captured_q == CAP_LAST)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_DONE: begin
          if (count_q == CNT_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM, pointer, counter and read-port registers.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      count_q    <= CNT_ZERO;
      captured_q <= CAP_ZERO;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      captured_q <= captured_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // FIFO storage; contents are deliberately left unreset.
  always_ff @(posedge crypto_clk) begin
    if (push_s && !reset_i) begin
      mem_q[wr_ptr_q] <= i_samples;
    end
  end

  assign o_ready    = ready_s;
  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_count    = count_q;
  assign o_empty    = (count_q == CNT_ZERO);
  assign o_full     = (count_q == DEPTH_C);
  assign o_captured = captured_q;
  assign o_overflow = overflow_q;
  assign o_busy     = (state_q == ST_CAPTURE);
  assign o_done     = (state_q == ST_DONE);

endmodule
